sdram_replay_prefetch: RTL and testbench

SDRAM_REPLAY_PREFETCH -- requirements
Module: sdram_replay_prefetch

---
 rtl/sdram_replay_prefetch.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_replay_prefetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_replay_prefetch.sv
// Replays recorded SDRAM words as a byte stream: a one-read-at-a-time prefetcher
// feeds a small FIFO that an external consumer drains with byte_taken pulses.
module sdram_replay_prefetch #(
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] IDLE_TIMEOUT = 32'h0BEBC200
) (
   input  logic        clk100m,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] end_addr,
   input  logic        ctrl_busy,
   output logic        rd_enable,
   output logic [23:0] rd_addr,
   input  logic [15:0] rd_data,
   input  logic        rd_ready,
   input  logic        byte_taken,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   output logic        active,
   output logic        underrun
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   // state       | meaning
   // S_IDLE      | apply pending rewind, or launch a read when room and data remain
   // S_ISSUE     | rd_enable held until the controller reports busy
   // S_WAIT_BUSY | controller working; first rd_ready byte goes into the FIFO
   // S_WAIT_DONE | advance rd_addr; push 8'h00 if no data ever arrived
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

   state_t        state_q, state_d;
   logic          rd_enable_q, rd_enable_d;
   logic [23:0]   rd_addr_q, rd_addr_d;
   logic          got_q, got_d;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    out_byte_q, out_byte_d;
   logic          out_valid_q, out_valid_d;
   logic          active_q, active_d;
   logic          underrun_q, underrun_d;
   logic          pending_q, pending_d;
   logic [31:0]   idle_cnt_q, idle_cnt_d;
   logic          push, pop, flush, timeout, in_range;
   logic [7:0]    push_byte;
   logic          unused_rd_data_hi;

   assign in_range          = (rd_addr_q < end_addr);
   assign unused_rd_data_hi = ^rd_data[15:8];

   always_comb begin
      state_d     = state_q;
      rd_enable_d = 1'b0;
      rd_addr_d   = rd_addr_q;
      got_d       = got_q;
      push        = 1'b0;
      push_byte   = 8'h00;
      flush       = 1'b0;
      case (state_q)
         S_IDLE: begin
            // a start seen here rewinds at once instead of wasting a read
            if (pending_q || start) begin
               flush     = 1'b1;
               rd_addr_d = 24'd0;
            end else if (active_q && (count_q < CW'(DEPTH)) && in_range) begin
               state_d     = S_ISSUE;
               rd_enable_d = 1'b1;
               got_d       = 1'b0;
            end
         end
         S_ISSUE: begin
            if (ctrl_busy) begin
               state_d = S_WAIT_BUSY;
            end else begin
               rd_enable_d = 1'b1;
            end
         end
         S_WAIT_BUSY: begin
            if (rd_ready && !got_q) begin
               push      = 1'b1;
               push_byte = rd_data[7:0];
               got_d     = 1'b1;
            end
            if (!ctrl_busy) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            push      = !got_q;
            rd_addr_d = rd_addr_q + 24'd1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      timeout    = 1'b0;
      idle_cnt_d = idle_cnt_q;
      if (start || byte_taken) begin
         idle_cnt_d = 32'd0;
      end else if (active_q) begin
         if (idle_cnt_q == IDLE_TIMEOUT - 32'd1) begin
            idle_cnt_d = 32'd0;
            timeout    = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
         end
      end

      pending_d = pending_q;
      if (flush) begin
         pending_d = 1'b0;
      end
      if (timeout || (start && (state_q != S_IDLE))) begin
         pending_d = 1'b1;
      end

      active_d   = active_q | start;
      underrun_d = underrun_q;
      if (start) begin
         underrun_d = 1'b0;
      end else if (byte_taken && (count_q == '0) && in_range) begin
         underrun_d = 1'b1;
      end
   end

   always_comb begin
      pop      = byte_taken && (count_q != '0) && !flush;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_byte;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      // head is precomputed so out_byte/out_valid come straight from flops
      out_valid_d = (count_d != '0);
      out_byte_d  = out_valid_d ? mem_d[rd_ptr_d] : 8'h00;
   end

   always_ff @(posedge clk100m) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rd_enable_q <= 1'b0;
         rd_addr_q   <= 24'd0;
         got_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_byte_q  <= 8'h00;
         out_valid_q <= 1'b0;
         active_q    <= 1'b0;
         underrun_q  <= 1'b0;
         pending_q   <= 1'b0;
         idle_cnt_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         rd_enable_q <= rd_enable_d;
         rd_addr_q   <= rd_addr_d;
         got_q       <= got_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_byte_q  <= out_byte_d;
         out_valid_q <= out_valid_d;
         active_q    <= active_d;
         underrun_q  <= underrun_d;
         pending_q   <= pending_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   always_ff @(posedge clk100m) begin
      mem_q <= mem_d;
   end

   assign rd_enable = rd_enable_q;
   assign rd_addr   = rd_addr_q;
   assign out_byte  = out_byte_q;
   assign out_valid = out_valid_q;
   assign active    = active_q;
   assign underrun  = underrun_q;
endmodule

// File: tb/tb_sdram_replay_prefetch.sv
// Scoreboard bench: directed scenarios push expected bytes; a monitor compares
// out_byte on every consumer handshake. A behavioural controller serves reads.
module tb_sdram_replay_prefetch;
   logic        clk100m = 1'b0;
   logic        reset, start, ctrl_busy, rd_enable, rd_ready, byte_taken;
   logic        out_valid, active, underrun;
   logic [23:0] end_addr, rd_addr;
   logic [15:0] rd_data;
   logic [7:0]  out_byte;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q [$];
   logic [23:0] rd_log [$];
   int          hs_cnt = 0;
   int          m_busy_delay = 0;
   int          m_ready_delay = 1;
   int          m_hold = 1;

   sdram_replay_prefetch #(.DEPTH(4), .IDLE_TIMEOUT(32'd100)) dut (
      .clk100m   (clk100m),
      .reset     (reset),
      .start     (start),
      .end_addr  (end_addr),
      .ctrl_busy (ctrl_busy),
      .rd_enable (rd_enable),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready),
      .byte_taken(byte_taken),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .active    (active),
      .underrun  (underrun)
   );

   always #5 clk100m = ~clk100m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // main drives at +2 after the edge, the controller model at +1
   task automatic tick();
      @(posedge clk100m);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_take();
      byte_taken = 1'b1;
      tick();
      byte_taken = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (!ctrl_busy && n < 100) begin
         tick();
         n++;
      end
      check(name, {31'd0, ctrl_busy}, 32'd1);
   endtask

   function automatic logic [23:0] log_at(input int i);
      return (rd_log.size() > i) ? rd_log[i] : 24'hFFFFFF;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd_enable"}, {31'd0, rd_enable}, 32'd0);
      check({tag, "_rd_addr"},   {8'd0, rd_addr},    32'd0);
      check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_out_byte"},  {24'd0, out_byte},  32'd0);
      check({tag, "_active"},    {31'd0, active},    32'd0);
      check({tag, "_underrun"},  {31'd0, underrun},  32'd0);
   endtask

   // SDRAM controller model: word at address a is 16'h0011 * (a+1)
   initial begin
      logic [23:0] a;
      logic [7:0]  lo;
      ctrl_busy = 1'b0;
      rd_ready  = 1'b0;
      rd_data   = 16'h0000;
      forever begin
         @(posedge clk100m);
         #1;
         if (rd_enable) begin
            a = rd_addr;
            rd_log.push_back(a);
            hs_cnt++;
            repeat (m_busy_delay) begin @(posedge clk100m); #1; end
            ctrl_busy = 1'b1;
            repeat (m_ready_delay) begin @(posedge clk100m); #1; end
            lo       = (a[7:0] + 8'd1) * 8'h11;
            rd_data  = {8'h00, lo};
            rd_ready = 1'b1;
            @(posedge clk100m);
            #1;
            rd_ready = 1'b0;
            repeat (m_hold) begin @(posedge clk100m); #1; end
            ctrl_busy = 1'b0;
         end
      end
   end

   // scoreboard monitor: every consumer handshake must match the queue head
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk100m);
         if (byte_taken && out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got %0h expected none (t=%0t)", out_byte, $time);
            end else begin
               e = exp_q.pop_front();
               check("sb_byte", {24'd0, out_byte}, {24'd0, e});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hs_base;
      int log_base;
      logic [7:0] basic_exp [5];
      basic_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      reset      = 1'b1;
      start      = 1'b0;
      end_addr   = 24'd0;
      byte_taken = 1'b0;
      repeat (3) tick();
      check_reset_outputs("por");
      reset = 1'b0;
      tick();

      // basic replay
      end_addr = 24'd5;
      hs_base  = hs_cnt;
      foreach (basic_exp[i]) exp_q.push_back(basic_exp[i]);
      pulse_start();
      check("basic_active", {31'd0, active}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         repeat (20) tick();
         pulse_take();
      end
      repeat (20) tick();
      check("basic_valid_end", {31'd0, out_valid}, 32'd0);
      check("basic_byte_end", {24'd0, out_byte}, 32'd0);
      check("basic_handshakes", hs_cnt - hs_base, 32'd5);
      check("basic_underrun", {31'd0, underrun}, 32'd0);
      check("basic_sb_drained", exp_q.size(), 32'd0);
      pulse_take();
      tick();
      check("past_end_no_underrun", {31'd0, underrun}, 32'd0);

      // backpressure
      do_reset();
      end_addr = 24'd10;
      hs_base  = hs_cnt;
      log_base = rd_log.size();
      pulse_start();
      repeat (60) tick();
      check("bp_reads", hs_cnt - hs_base, 32'd4);
      check("bp_full_valid", {31'd0, out_valid}, 32'd1);
      check("bp_head", {24'd0, out_byte}, 32'h11);
      check("bp_idle_rd_enable", {31'd0, rd_enable}, 32'd0);
      check("bp_rd_addr", {8'd0, rd_addr}, 32'd4);
      exp_q.push_back(8'h11);
      pulse_take();
      repeat (20) tick();
      check("bp_one_more", hs_cnt - hs_base, 32'd5);
      check("bp_fifth_addr", {8'd0, log_at(log_base + 4)}, 32'd4);
      check("bp_rd_addr_after", {8'd0, rd_addr}, 32'd5);

      // underrun with a slow controller
      do_reset();
      m_busy_delay = 30;
      end_addr     = 24'd4;
      hs_base      = hs_cnt;
      for (int i = 0; i < 4; i++) exp_q.push_back(basic_exp[i]);
      pulse_start();
      for (int i = 0; i < 100; i++) begin
         pulse_take();
         tick();
      end
      check("ur_underrun", {31'd0, underrun}, 32'd1);
      check("ur_reads", hs_cnt - hs_base, 32'd4);
      check("ur_sb_drained", exp_q.size(), 32'd0);
      check("ur_empty", {31'd0, out_valid}, 32'd0);
      check("ur_rd_addr", {8'd0, rd_addr}, 32'd4);
      m_busy_delay = 0;

      // rewind requested while a read is in flight
      do_reset();
      m_ready_delay = 4;
      end_addr      = 24'd5;
      log_base      = rd_log.size();
      pulse_start();
      wait_busy("rw_busy_seen");
      tick();
      pulse_start();
      begin
         int n = 0;
         logic reen = 1'b0;
         while (ctrl_busy && n < 30) begin
            if (rd_enable) reen = 1'b1;
            tick();
            n++;
         end
         check("rw_no_reissue", {31'd0, reen}, 32'd0);
      end
      begin
         int n = 0;
         while (rd_log.size() < log_base + 4 && n < 100) begin
            tick();
            n++;
         end
      end
      repeat (15) tick();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      for (int i = 0; i < 3; i++) begin
         pulse_take();
         tick();
      end
      check("rw_first_addr", {8'd0, log_at(log_base)}, 32'd0);
      check("rw_restart_addr", {8'd0, log_at(log_base + 1)}, 32'd0);
      check("rw_next_addr", {8'd0, log_at(log_base + 2)}, 32'd1);
      check("rw_sb_drained", exp_q.size(), 32'd0);
      m_ready_delay = 1;

      // inactivity timeout rewinds and refills
      do_reset();
      end_addr = 24'd3;
      hs_base  = hs_cnt;
      log_base = rd_log.size();
      pulse_start();
      repeat (99) tick();
      check("ia_reads_before", hs_cnt - hs_base, 32'd3);
      tick();
      check("ia_not_early", {8'd0, rd_addr}, 32'd3);
      tick();
      check("ia_rewind_addr", {8'd0, rd_addr}, 32'd0);
      check("ia_flushed", {31'd0, out_valid}, 32'd0);
      repeat (30) tick();
      check("ia_refill_reads", hs_cnt - hs_base, 32'd6);
      check("ia_refill_addr", {8'd0, log_at(log_base + 3)}, 32'd0);
      check("ia_rd_addr_end", {8'd0, rd_addr}, 32'd3);

      // byte_taken on the last cycle before timeout keeps the FIFO
      do_reset();
      hs_base = hs_cnt;
      pulse_start();
      repeat (99) tick();
      exp_q.push_back(8'h11);
      pulse_take();
      repeat (40) tick();
      check("ia_saved_reads", hs_cnt - hs_base, 32'd3);
      check("ia_saved_addr", {8'd0, rd_addr}, 32'd3);
      check("ia_saved_head", {24'd0, out_byte}, 32'h22);

      // reset in the middle of a read, late rd_ready afterwards
      do_reset();
      m_ready_delay = 3;
      end_addr      = 24'd5;
      hs_base       = hs_cnt;
      pulse_start();
      pulse_take();
      wait_busy("rst_busy_seen");
      check("rst_pre_underrun", {31'd0, underrun}, 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_outputs("rst_now");
      repeat (10) tick();
      check_reset_outputs("rst_late");
      check("rst_no_new_reads", hs_cnt - hs_base, 32'd1);
      m_ready_delay = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
